// File: rtl/dmem_responder.sv
// Stallable data-memory target for the core's load/store port: valid/ready request in,
// programmable wait states, byte/half/word access on a word array, extended data or error out.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | counting down wait states for the latched request
  // S_RESP | response held until the core takes it
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [2:0]    w_funct3;
  logic [31:0]   w_wdata;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_wr_word;
  logic [31:0]   w_rep;
  logic [3:0]    w_be;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld_data;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign w_accept   = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = (WS == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt <= 4'd1) w_state_nxt = S_RESP;
      S_RESP: if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // With zero wait states the access happens on the accept edge, so use the live request.
  assign w_we     = (r_state == S_IDLE) ? req_we     : r_we;
  assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
  assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
  assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

  always_comb begin
    w_err = 1'b0;
    case (w_funct3)
      3'b000, 3'b100: w_err = 1'b0;
      3'b001, 3'b101: w_err = w_addr[0];
      3'b010:         w_err = (w_addr[1:0] != 2'b00);
      default:        w_err = 1'b1;
    endcase
    if (w_we && w_funct3[2]) w_err = 1'b1;
    if (w_addr[31:2] >= DEPTH_L) w_err = 1'b1;
  end

  assign w_idx  = w_addr[AW+1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_be  = 4'b1111;
    w_rep = w_wdata;
    case (w_funct3[1:0])
      2'b00: begin
        w_be  = 4'b0001 << w_addr[1:0];
        w_rep = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be  = w_addr[1] ? 4'b1100 : 4'b0011;
        w_rep = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be  = 4'b1111;
        w_rep = w_wdata;
      end
    endcase
    w_wr_word = w_word;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_wr_word[8*i +: 8] = w_rep[8*i +: 8];
    end
  end

  always_comb begin
    case (w_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {24'h0, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_data = {16'h0, w_half};
      default: w_ld_data = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= WS;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'h0 : w_ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr;
      r_funct3 <= req_funct3;
      r_wdata  <= req_wdata;
    end
  end

  // Array is never cleared; a reset edge suppresses any write that would land on it.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_we && !w_err) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder using a byte-addressed reference model;
// one instance with WAIT_STATES=1, one with WAIT_STATES=3 for the reset-in-wait case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        sel;

  logic        v1, v3;
  logic        rr1, rv1, er1, rr3, rv3, er3;
  logic [31:0] rd1, rd3;

  logic        m_req_ready, m_resp_valid, m_err;
  logic [31:0] m_rdata;

  logic [7:0] m1 [256];
  logic [7:0] m3 [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign v1 = req_valid && !sel;
  assign v3 = req_valid && sel;
  assign m_req_ready  = sel ? rr3 : rr1;
  assign m_resp_valid = sel ? rv3 : rv1;
  assign m_rdata      = sel ? rd3 : rd1;
  assign m_err        = sel ? er3 : er1;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) u_w1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(er1)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rr3), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(er3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference: legality by rule, memory as 256 little-endian bytes.
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int sz;
    logic legal;
    logic [31:0] v;
    sz = size_of(f3);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || ((addr % sz) != 0) || (addr >= 32'd256);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) begin
          if (sel) m3[addr[7:0] + 8'(i)] = wd[8*i +: 8];
          else     m1[addr[7:0] + 8'(i)] = wd[8*i +: 8];
        end
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) begin
          v = v | ((sel ? 32'(m3[addr[7:0] + 8'(i)]) : 32'(m1[addr[7:0] + 8'(i)])) << (8*i));
        end
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        rd = v;
      end
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold);
    logic exp_err;
    logic [31:0] exp_rd;
    int n;
    int w;
    w = sel ? 3 : 1;
    model(we, addr, f3, wd, exp_err, exp_rd);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, m_req_ready}, 32'd1);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(negedge clk);
    // Keep valid asserted with garbage: must be ignored while busy.
    req_we     = ~we;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
    req_wdata  = $urandom;
    n = 1;
    while (!m_resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, w + 1);
    if (m_resp_valid) begin
      for (int k = 0; k < hold; k++) begin
        chk("hold_valid", {31'b0, m_resp_valid}, 32'd1);
        chk("hold_rdata", m_rdata, exp_rd);
        chk("hold_err", {31'b0, m_err}, {31'b0, exp_err});
        chk("hold_req_ready", {31'b0, m_req_ready}, 32'd0);
        @(negedge clk);
      end
      chk("rdata", m_rdata, exp_rd);
      chk("err", {31'b0, m_err}, {31'b0, exp_err});
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("valid_drop", {31'b0, m_resp_valid}, 32'd0);
      chk("req_ready_back", {31'b0, m_req_ready}, 32'd1);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    reset = 1'b1;
    sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    req_addr = 32'h0; req_funct3 = 3'b0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready1", {31'b0, rr1}, 32'd1);
    chk("rst_resp_valid1", {31'b0, rv1}, 32'd0);
    chk("rst_rdata1", rd1, 32'h0);
    chk("rst_err1", {31'b0, er1}, 32'd0);
    chk("rst_req_ready3", {31'b0, rr3}, 32'd1);
    chk("rst_resp_valid3", {31'b0, rv3}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) do_txn(1'b1, 32'(i * 4), 3'b010, $urandom, 0);

    do_txn(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0);
    do_txn(1'b0, 32'h10, 3'b010, 32'h0, 0);
    do_txn(1'b1, 32'h11, 3'b000, 32'h000000A5, 0);
    do_txn(1'b0, 32'h11, 3'b000, 32'h0, 0);
    do_txn(1'b0, 32'h11, 3'b100, 32'h0, 0);
    do_txn(1'b0, 32'h10, 3'b010, 32'h0, 0);
    do_txn(1'b1, 32'h12, 3'b001, 32'h00008001, 0);
    do_txn(1'b0, 32'h12, 3'b001, 32'h0, 0);
    do_txn(1'b0, 32'h12, 3'b101, 32'h0, 0);
    do_txn(1'b0, 32'h10, 3'b010, 32'h0, 0);
    do_txn(1'b0, 32'h13, 3'b010, 32'h0, 0);
    do_txn(1'b1, 32'h11, 3'b001, 32'hFFFF, 0);
    do_txn(1'b0, 32'h10, 3'b010, 32'h0, 5);
    do_txn(1'b0, 32'h100, 3'b010, 32'h0, 0);
    do_txn(1'b0, 32'h10, 3'b011, 32'h0, 0);
    do_txn(1'b1, 32'h14, 3'b100, 32'h12, 0);

    for (int i = 0; i < 80; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 263));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 32'd1);
      do_txn(1'($urandom_range(0, 1)), a, f3, $urandom, $urandom_range(0, 2));
    end

    // W=3: reset during the second wait cycle abandons the store.
    sel = 1'b1;
    do_txn(1'b1, 32'h20, 3'b010, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_funct3 = 3'b010; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("w3_in_wait_req_ready", {31'b0, rr3}, 32'd0);
    chk("w3_in_wait_valid", {31'b0, rv3}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("w3_rst_req_ready", {31'b0, rr3}, 32'd1);
    chk("w3_rst_valid", {31'b0, rv3}, 32'd0);
    chk("w3_rst_rdata", rd3, 32'h0);
    chk("w3_rst_err", {31'b0, er3}, 32'd0);
    repeat (4) @(negedge clk);
    chk("w3_stay_idle", {31'b0, rv3}, 32'd0);
    do_txn(1'b0, 32'h20, 3'b010, 32'h0, 0);
    do_txn(1'b1, 32'h24, 3'b001, 32'hBEEF, 1);
    do_txn(1'b0, 32'h24, 3'b001, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
